// File: rtl/data_memory_controller_pkg.sv
// Shared funct3 encodings, FSM state encoding and access-size decode for the
// data memory controller.
package data_memory_controller_pkg;

  localparam int unsigned XLEN = 32;

  // Load/store funct3 encodings
  localparam logic [2:0] LOAD_LB   = 3'b000;
  localparam logic [2:0] LOAD_LH   = 3'b001;
  localparam logic [2:0] LOAD_LW   = 3'b010;
  localparam logic [2:0] LOAD_LBU  = 3'b100;
  localparam logic [2:0] LOAD_LHU  = 3'b101;
  localparam logic [2:0] STORE_SB  = 3'b000;
  localparam logic [2:0] STORE_SH  = 3'b001;
  localparam logic [2:0] STORE_SW  = 3'b010;

  // Access sizes in bytes
  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SIZE_B;
      2'b01:   return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

  function automatic logic f3_reserved(input logic is_write, input logic [2:0] f3);
    if (is_write) return !(f3 inside {STORE_SB, STORE_SH, STORE_SW});
    return !(f3 inside {LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU});
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] size);
    case (size)
      SIZE_B:  return 4'b0001;
      SIZE_H:  return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic nat_misaligned(input logic [2:0] size, input logic [1:0] off);
    return ((size == SIZE_H) && off[0]) || ((size == SIZE_W) && (off != 2'd0));
  endfunction

  function automatic logic crosses_word(input logic [2:0] size, input logic [1:0] off);
    return (3'(off) + size) > 3'd4;
  endfunction

endpackage

// File: rtl/data_memory_controller_aligner.sv
// memory_lane_aligner: combinational byte-lane placement for stores and
// extraction plus sign/zero extension for loads across a two-word window.
module memory_lane_aligner
  import data_memory_controller_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] load_low,
  input  logic [31:0] load_high,
  output logic [7:0]  byte_mask,
  output logic [63:0] store_lanes,
  output logic [31:0] load_result
);

  logic [2:0]  size;
  logic [5:0]  shamt;
  logic [31:0] load_shifted;
  logic        sign_en;

  // Lane shift, mask generation and load extend
  always_comb begin
    size         = f3_size(funct3);
    shamt        = {1'b0, offset, 3'b000};
    sign_en      = ~funct3[2];
    byte_mask    = 8'(size_mask(size)) << offset;
    store_lanes  = 64'(store_data) << shamt;
    load_shifted = 32'({load_high, load_low} >> shamt);
    case (size)
      SIZE_B:  load_result = {{24{sign_en & load_shifted[7]}},  load_shifted[7:0]};
      SIZE_H:  load_result = {{16{sign_en & load_shifted[15]}}, load_shifted[15:0]};
      default: load_result = load_shifted;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// Load/store sequencer between core and data memory. Define
// MISALIGNED_SPLIT_EN to split word-crossing accesses into two transactions;
// without it, naturally misaligned accesses fault without touching memory.
module data_memory_controller
  import data_memory_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] register_file_read_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] register_file_write_data,
  output logic        misaligned_fault,
  output logic        dm_request,
  output logic        dm_write,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  output logic [3:0]  dm_write_mask,
  input  logic        dm_ready,
  input  logic [31:0] dm_read_data
);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] address_q, address_d;
  logic [31:0] store_data_q, store_data_d;
  logic        is_write_q, is_write_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [31:0] rf_data_q, rf_data_d;
  logic        dm_request_q, dm_request_d;
  logic        dm_write_q, dm_write_d;
  logic [31:0] dm_address_q, dm_address_d;
  logic [31:0] dm_write_data_q, dm_write_data_d;
  logic [3:0]  dm_write_mask_q, dm_write_mask_d;

  logic        req_c, wr_c, in_idle_c, sel_write_c, fault_c, complete_c;
  logic [2:0]  sel_funct3_c, size_c;
  logic [31:0] sel_address_c, sel_store_c, sel_low_c, base_c;
  logic [1:0]  off_c;
  logic [7:0]  byte_mask_c;
  logic [63:0] store_lanes_c;
  logic [31:0] load_result_c;

`ifdef MISALIGNED_SPLIT_EN
  logic [31:0] low_word_q, low_word_d;
  logic        crossing_c;
`else
  logic        unused_high_lanes_c;
`endif

  // Aligner sees the live request while idle and the latched one afterwards
  always_comb begin
    req_c         = memory_read | memory_write;
    wr_c          = memory_write & ~memory_read;
    in_idle_c     = (state_q == S_IDLE);
    sel_funct3_c  = in_idle_c ? funct3 : funct3_q;
    sel_address_c = in_idle_c ? address : address_q;
    sel_store_c   = in_idle_c ? register_file_read_data : store_data_q;
    sel_write_c   = in_idle_c ? wr_c : is_write_q;
    off_c         = sel_address_c[1:0];
    base_c        = {sel_address_c[31:2], 2'b00};
    size_c        = f3_size(sel_funct3_c);
`ifdef MISALIGNED_SPLIT_EN
    sel_low_c     = (state_q == S_SECOND) ? low_word_q : dm_read_data;
    crossing_c    = crosses_word(size_c, off_c);
    fault_c       = f3_reserved(sel_write_c, sel_funct3_c);
`else
    sel_low_c     = dm_read_data;
    fault_c       = f3_reserved(sel_write_c, sel_funct3_c) | nat_misaligned(size_c, off_c);
`endif
  end

`ifndef MISALIGNED_SPLIT_EN
  assign unused_high_lanes_c = ^{byte_mask_c[7:4], store_lanes_c[63:32]};
`endif

  memory_lane_aligner u_aligner (
    .offset      (off_c),
    .funct3      (sel_funct3_c),
    .store_data  (sel_store_c),
    .load_low    (sel_low_c),
    .load_high   (dm_read_data),
    .byte_mask   (byte_mask_c),
    .store_lanes (store_lanes_c),
    .load_result (load_result_c)
  );

  // Next-state, capture and registered-output logic
  always_comb begin
    state_d         = state_q;
    funct3_d        = funct3_q;
    address_d       = address_q;
    store_data_d    = store_data_q;
    is_write_d      = is_write_q;
    done_d          = 1'b0;
    fault_d         = fault_q;
    rf_data_d       = rf_data_q;
    dm_request_d    = dm_request_q;
    dm_write_d      = dm_write_q;
    dm_address_d    = dm_address_q;
    dm_write_data_d = dm_write_data_q;
    dm_write_mask_d = dm_write_mask_q;
    complete_c      = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    low_word_d      = low_word_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          funct3_d     = funct3;
          address_d    = address;
          store_data_d = register_file_read_data;
          is_write_d   = wr_c;
          if (fault_c) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            fault_d   = 1'b1;
            rf_data_d = '0;
          end else begin
            state_d         = S_FIRST;
            dm_request_d    = 1'b1;
            dm_write_d      = wr_c;
            dm_address_d    = base_c;
            dm_write_data_d = wr_c ? store_lanes_c[31:0] : '0;
            dm_write_mask_d = wr_c ? byte_mask_c[3:0] : '0;
          end
        end
      end
      S_FIRST: begin
        if (dm_ready) begin
`ifdef MISALIGNED_SPLIT_EN
          low_word_d = dm_read_data;
          if (crossing_c) begin
            state_d         = S_SECOND;
            dm_address_d    = base_c + 32'd4;
            dm_write_data_d = is_write_q ? store_lanes_c[63:32] : '0;
            dm_write_mask_d = is_write_q ? byte_mask_c[7:4] : '0;
          end else begin
            complete_c = 1'b1;
          end
`else
          complete_c = 1'b1;
`endif
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      S_SECOND: begin
        if (dm_ready) complete_c = 1'b1;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (complete_c) begin
      state_d         = S_DONE;
      done_d          = 1'b1;
      fault_d         = 1'b0;
      rf_data_d       = is_write_q ? '0 : load_result_c;
      dm_request_d    = 1'b0;
      dm_write_d      = 1'b0;
      dm_address_d    = '0;
      dm_write_data_d = '0;
      dm_write_mask_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      funct3_q        <= '0;
      address_q       <= '0;
      store_data_q    <= '0;
      is_write_q      <= 1'b0;
      done_q          <= 1'b0;
      fault_q         <= 1'b0;
      rf_data_q       <= '0;
      dm_request_q    <= 1'b0;
      dm_write_q      <= 1'b0;
      dm_address_q    <= '0;
      dm_write_data_q <= '0;
      dm_write_mask_q <= '0;
`ifdef MISALIGNED_SPLIT_EN
      low_word_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      funct3_q        <= funct3_d;
      address_q       <= address_d;
      store_data_q    <= store_data_d;
      is_write_q      <= is_write_d;
      done_q          <= done_d;
      fault_q         <= fault_d;
      rf_data_q       <= rf_data_d;
      dm_request_q    <= dm_request_d;
      dm_write_q      <= dm_write_d;
      dm_address_q    <= dm_address_d;
      dm_write_data_q <= dm_write_data_d;
      dm_write_mask_q <= dm_write_mask_d;
`ifdef MISALIGNED_SPLIT_EN
      low_word_q      <= low_word_d;
`endif
    end
  end

  // Stall is gated by reset so the core sees no stall while held in reset
  assign busy = reset_n & ((state_q == S_FIRST) | (state_q == S_SECOND) |
                           ((state_q == S_IDLE) & req_c));

  assign done                     = done_q;
  assign misaligned_fault         = fault_q;
  assign register_file_write_data = rf_data_q;
  assign dm_request               = dm_request_q;
  assign dm_write                 = dm_write_q;
  assign dm_address               = dm_address_q;
  assign dm_write_data            = dm_write_data_q;
  assign dm_write_mask            = dm_write_mask_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Bench for data_memory_controller: directed scenarios plus randomized
// loads/stores against a byte-level reference model.
module tb_data_memory_controller;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memory_read, memory_write;
  logic [2:0]  funct3;
  logic [31:0] address, register_file_read_data;
  logic        busy, done, misaligned_fault;
  logic [31:0] register_file_write_data;
  logic        dm_request, dm_write, dm_ready;
  logic [31:0] dm_address, dm_write_data, dm_read_data;
  logic [3:0]  dm_write_mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_memory_controller dut (
    .clk(clk), .reset_n(reset_n),
    .memory_read(memory_read), .memory_write(memory_write),
    .funct3(funct3), .address(address),
    .register_file_read_data(register_file_read_data),
    .busy(busy), .done(done),
    .register_file_write_data(register_file_write_data),
    .misaligned_fault(misaligned_fault),
    .dm_request(dm_request), .dm_write(dm_write),
    .dm_address(dm_address), .dm_write_data(dm_write_data),
    .dm_write_mask(dm_write_mask),
    .dm_ready(dm_ready), .dm_read_data(dm_read_data)
  );

  // ---------------- reference model ----------------
  function automatic int model_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit model_fault(input bit wr, input logic [2:0] f3, input int off);
    int sz;
    bit reserved, natmis;
    sz       = model_size(f3);
    reserved = wr ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 > 3'd5));
    natmis   = ((sz == 2) && (off % 2 == 1)) || ((sz == 4) && (off != 0));
    return reserved || (!SPLIT && natmis);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] lo, input logic [31:0] hi);
    logic [7:0]  b [8];
    logic [31:0] val;
    int          sz;
    for (int i = 0; i < 4; i++) begin
      b[i]   = lo[8*i +: 8];
      b[i+4] = hi[8*i +: 8];
    end
    sz  = model_size(f3);
    val = '0;
    for (int k = 0; k < sz; k++) val[8*k +: 8] = b[off+k];
    if (!f3[2] && sz < 4 && b[off+sz-1][7])
      for (int k = sz; k < 4; k++) val[8*k +: 8] = 8'hFF;
    return val;
  endfunction

  // One complete transaction: drives request, plays memory, checks every
  // cycle against the model; returns observed result, fault and done cycle.
  task automatic do_txn(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] lo, input logic [31:0] hi,
                        input int w0, input int w1,
                        output logic [31:0] o_data, output logic o_fault, output int o_cycles);
    int          off, sz, n, exp_cycles, a, idx;
    int          wleft [2];
    bit          flt, rdy_pend, got;
    logic [31:0] base, exp_data, ad, dd;
    logic [3:0]  md;
    off  = int'(addr[1:0]);
    sz   = model_size(f3);
    flt  = model_fault(wr, f3, off);
    n    = flt ? 0 : ((off + sz > 4) ? 2 : 1);
    exp_cycles = flt ? 1 : (n + 1 + w0 + ((n == 2) ? w1 : 0));
    base = {addr[31:2], 2'b00};
    exp_data = (flt || wr) ? 32'h0 : model_load(f3, off, lo, hi);
    wleft[0] = w0;
    wleft[1] = w1;
    o_data = 'x; o_fault = 'x; o_cycles = -1;

    memory_read  = !wr;
    memory_write = wr;
    funct3       = f3;
    address      = addr;
    register_file_read_data = wdata;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_on_request: got %b expected 1 (f3=%0d addr=%h)", busy, f3, addr);
    end

    a = 0; rdy_pend = 0; got = 0;
    for (int c = 1; c <= 64 && !got; c++) begin
      @(posedge clk);
      if (rdy_pend) a++;
      rdy_pend = 0;
      @(negedge clk);
      dm_ready     = 1'b0;
      dm_read_data = $urandom;
      if (done === 1'b1) begin
        got      = 1;
        o_cycles = c;
        o_data   = register_file_write_data;
        o_fault  = misaligned_fault;
      end else if (a < n) begin
        ad = base + 32'(4 * a);
        md = '0;
        dd = '0;
        if (wr) begin
          for (int j = 0; j < 4; j++) begin
            idx = 4 * a + j - off;
            if (idx >= 0 && idx < sz) md[j] = 1'b1;
            if (idx >= 0 && idx < 4)  dd[8*j +: 8] = wdata[8*idx +: 8];
          end
        end
        checks++;
        if ({busy, dm_request, dm_write, dm_address, dm_write_mask, dm_write_data} !==
            {1'b1, 1'b1, wr, ad, md, dd}) begin
          errors++;
          $display("FAIL access%0d cycle%0d: got busy=%b req=%b wr=%b addr=%h mask=%b data=%h expected busy=1 req=1 wr=%b addr=%h mask=%b data=%h",
                   a, c, busy, dm_request, dm_write, dm_address, dm_write_mask, dm_write_data,
                   wr, ad, md, dd);
        end
        if (wleft[a] > 0) wleft[a]--;
        else begin
          dm_ready     = 1'b1;
          dm_read_data = (a == 0) ? lo : hi;
          rdy_pend     = 1;
        end
      end else begin
        checks++;
        errors++;
        $display("FAIL done_missing: cycle %0d done=%b expected 1", c, done);
        got = 1;
      end
    end

    checks++;
    if (o_cycles != exp_cycles) begin
      errors++;
      $display("FAIL latency: got %0d expected %0d (wr=%0d f3=%0d addr=%h)", o_cycles, exp_cycles, wr, f3, addr);
    end
    if (o_cycles > 0) begin
      checks++;
      if ({busy, dm_request, misaligned_fault} !== {1'b0, 1'b0, flt}) begin
        errors++;
        $display("FAIL done_state: got busy=%b req=%b fault=%b expected 0 0 %b", busy, dm_request, misaligned_fault, flt);
      end
      if (!wr || flt) begin
        checks++;
        if (register_file_write_data !== exp_data) begin
          errors++;
          $display("FAIL load_data: got %h expected %h (f3=%0d addr=%h lo=%h hi=%h)",
                   register_file_write_data, exp_data, f3, addr, lo, hi);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    memory_read  = 1'b0;
    memory_write = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got %b expected 0 one cycle after done", done);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; memory_read = 1'b0; memory_write = 1'b0; funct3 = '0;
    address = '0; register_file_read_data = '0; dm_ready = 1'b0; dm_read_data = '0;
    #2;
    checks++;
    if ({busy, done, misaligned_fault, dm_request, dm_write, register_file_write_data,
         dm_address, dm_write_data, dm_write_mask} !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b fault=%b req=%b wr=%b rf=%h addr=%h data=%h mask=%b expected all 0",
               busy, done, misaligned_fault, dm_request, dm_write, register_file_write_data,
               dm_address, dm_write_data, dm_write_mask);
    end
    memory_read = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_reset: got %b expected 0", busy);
    end
    memory_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_store_word();
    logic [31:0] d; logic f; int cyc;
    do_txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, $urandom, $urandom, 0, 0, d, f, cyc);
    checks++;
    if ({f, 32'(cyc)} !== {1'b0, 32'd2}) begin
      errors++;
      $display("FAIL sw_aligned: got fault=%b cycles=%0d expected fault=0 cycles=2", f, cyc);
    end
  endtask

  task automatic test_load_byte();
    logic [31:0] d; logic f; int cyc;
    do_txn(1'b0, 3'd0, 32'h103, '0, 32'h80FF_0000, $urandom, 0, 0, d, f, cyc);
    checks++;
    if (d !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_sign: got %h expected ffffff80", d);
    end
    do_txn(1'b0, 3'd4, 32'h103, '0, 32'h80FF_0000, $urandom, 1, 0, d, f, cyc);
    checks++;
    if (d !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_zero: got %h expected 00000080", d);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] d; logic f; int cyc;
    do_txn(1'b1, 3'd1, 32'h106, 32'h0000_A1B2, $urandom, $urandom, 3, 0, d, f, cyc);
    checks++;
    if ({f, 32'(cyc)} !== {1'b0, 32'd5}) begin
      errors++;
      $display("FAIL sh_wait: got fault=%b cycles=%0d expected fault=0 cycles=5", f, cyc);
    end
  endtask

  task automatic test_split_load();
    logic [31:0] d; logic f; int cyc;
    do_txn(1'b0, 3'd2, 32'h1FE, '0, 32'h3344_ABCD, 32'h5566_1122, 0, 0, d, f, cyc);
    checks++;
`ifdef MISALIGNED_SPLIT_EN
    if ({d, f, 32'(cyc)} !== {32'h1122_3344, 1'b0, 32'd3}) begin
      errors++;
      $display("FAIL lw_split: got data=%h fault=%b cycles=%0d expected 11223344 0 3", d, f, cyc);
    end
`else
    if ({d, f, 32'(cyc)} !== {32'h0, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL lw_misaligned_fault: got data=%h fault=%b cycles=%0d expected 00000000 1 1", d, f, cyc);
    end
`endif
  endtask

  task automatic test_split_store_wrap();
    logic [31:0] d; logic f; int cyc;
    do_txn(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h1122_3344, $urandom, $urandom, 1, 2, d, f, cyc);
    checks++;
`ifdef MISALIGNED_SPLIT_EN
    if ({f, 32'(cyc)} !== {1'b0, 32'd6}) begin
      errors++;
      $display("FAIL sw_wrap_split: got fault=%b cycles=%0d expected 0 6", f, cyc);
    end
`else
    if ({f, 32'(cyc)} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL sw_wrap_fault: got fault=%b cycles=%0d expected 1 1", f, cyc);
    end
`endif
  endtask

  task automatic test_reserved();
    logic [31:0] d; logic f; int cyc;
    do_txn(1'b0, 3'd3, 32'h200, '0, $urandom, $urandom, 0, 0, d, f, cyc);
    checks++;
    if ({d, f, 32'(cyc)} !== {32'h0, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL reserved_load: got data=%h fault=%b cycles=%0d expected 0 1 1", d, f, cyc);
    end
    do_txn(1'b1, 3'd5, 32'h204, 32'h1234_5678, $urandom, $urandom, 0, 0, d, f, cyc);
    checks++;
    if ({f, 32'(cyc)} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL reserved_store: got fault=%b cycles=%0d expected 1 1", f, cyc);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] d; logic f; int cyc;
    memory_read = 1'b1; memory_write = 1'b0; funct3 = 3'd2;
`ifdef MISALIGNED_SPLIT_EN
    address = 32'h1FE;
`else
    address = 32'h100;
`endif
    @(posedge clk);
    @(negedge clk);
`ifdef MISALIGNED_SPLIT_EN
    dm_ready = 1'b1; dm_read_data = $urandom;
    @(posedge clk);
    @(negedge clk);
    dm_ready = 1'b0;
    checks++;
    if ({dm_request, dm_address} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL second_access: got req=%b addr=%h expected 1 00000200", dm_request, dm_address);
    end
`else
    checks++;
    if ({dm_request, dm_address} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL first_access: got req=%b addr=%h expected 1 00000100", dm_request, dm_address);
    end
`endif
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, dm_request, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b req=%b done=%b expected 0 0 0", busy, dm_request, done);
    end
    @(posedge clk);
    @(negedge clk);
    memory_read = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: got done=%b expected 0", done);
    end
    reset_n = 1'b1;
    @(negedge clk);
    do_txn(1'b0, 3'd2, 32'h0, '0, 32'hCAFE_0123, $urandom, 0, 0, d, f, cyc);
    checks++;
    if ({d, f, 32'(cyc)} !== {32'hCAFE_0123, 1'b0, 32'd2}) begin
      errors++;
      $display("FAIL lw_after_reset: got data=%h fault=%b cycles=%0d expected cafe0123 0 2", d, f, cyc);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, addr; logic f; int cyc;
    for (int i = 0; i < 150; i++) begin
      addr = $urandom;
      if (i % 10 == 0) addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom,
             $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), d, f, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_wait_states();
    test_split_load();
    test_split_store_wrap();
    test_reserved();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
